nack_gap_detector: RTL and testbench

//  Tracks expected PSN of the received in-order packet stream and detects sequence gaps.

---
 rtl/nack_gap_detector.sv | 191 +++++++++++++++++++
 tb/tb_nack_gap_detector.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nack_gap_detector.sv
// Tracks the expected PSN of an in-order packet stream and turns every sequence gap into
// one or more {start PSN, length} NACK descriptors. Optional counters: NACK_GAP_STAT_EN.
module nack_gap_detector #(
    parameter int unsigned PSN_W    = 24,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_PSN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_psn_ld,
    input  logic [PSN_W-1:0] cfg_psn,
    input  logic [PSN_W-1:0] in_psn,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [PSN_W-1:0] nack_psn,
    output logic [LEN_W-1:0] nack_len,
    output logic             nack_vld,
    input  logic             nack_rdy
`ifdef NACK_GAP_STAT_EN
    ,
    output logic [31:0]      stat_inord,
    output logic [31:0]      stat_gap,
    output logic [31:0]      stat_dup
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    localparam logic [PSN_W-1:0] MAX_LEN_P = PSN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [PSN_W-1:0] INIT_P    = PSN_W'(INIT_PSN);
    localparam logic [PSN_W-1:0] ONE_P     = PSN_W'(1);

    state_t             state_r, state_s;
    logic [PSN_W-1:0]   e_psn_r, e_psn_s;
    logic [PSN_W-1:0]   nack_psn_r, nack_psn_s;
    logic [LEN_W-1:0]   nack_len_r, nack_len_s;
    logic               nack_vld_r, nack_vld_s;
    logic [PSN_W-1:0]   rem_r, rem_s;
    logic [PSN_W-1:0]   nxt_r, nxt_s;

    logic               in_rdy_s;
    logic               accept_s;
    logic               xfer_s;
    logic [PSN_W-1:0]   diff_s;
    logic               inord_s;
    logic               gap_s;
    logic [PSN_W-1:0]   chunk_s;

    // Acceptance is gated by the config pulse so a reload never races a packet.
    assign in_rdy_s = (state_r == IDLE) & ~nack_vld_r & ~cfg_psn_ld & ~rst;
    assign accept_s = in_vld & in_rdy_s;
    assign xfer_s   = nack_vld_r & nack_rdy;
    assign diff_s   = in_psn - e_psn_r;
    assign inord_s  = accept_s & (diff_s == '0);
    assign gap_s    = accept_s & (diff_s != '0) & ~diff_s[PSN_W-1];
    assign chunk_s  = (rem_r > MAX_LEN_P) ? MAX_LEN_P : rem_r;

    assign in_rdy   = in_rdy_s;
    assign nack_psn = nack_psn_r;
    assign nack_len = nack_len_r;
    assign nack_vld = nack_vld_r;

    // Next-state and next-descriptor computation for the IDLE/SPLIT sequencer.
    always_comb begin
        state_s    = state_r;
        e_psn_s    = e_psn_r;
        nack_psn_s = nack_psn_r;
        nack_len_s = nack_len_r;
        nack_vld_s = nack_vld_r;
        rem_s      = rem_r;
        nxt_s      = nxt_r;

        case (state_r)
            IDLE: begin
                if (gap_s) begin
                    nack_psn_s = e_psn_r;
                    nack_vld_s = 1'b1;
                    if (diff_s > MAX_LEN_P) begin
                        nack_len_s = MAX_LEN_L;
                        rem_s      = diff_s - MAX_LEN_P;
                        nxt_s      = e_psn_r + MAX_LEN_P;
                        state_s    = SPLIT;
                    end else begin
                        nack_len_s = LEN_W'(diff_s);
                    end
                end else if (xfer_s) begin
                    nack_vld_s = 1'b0;
                end else begin
                    nack_vld_s = nack_vld_r;
                end
            end
            SPLIT: begin
                // Next chunk replaces the transferred one in the same edge: no bubble.
                if (xfer_s) begin
                    nack_psn_s = nxt_r;
                    nack_len_s = LEN_W'(chunk_s);
                    nxt_s      = nxt_r + chunk_s;
                    rem_s      = rem_r - chunk_s;
                    if (rem_r <= MAX_LEN_P) begin
                        state_s = IDLE;
                    end else begin
                        state_s = SPLIT;
                    end
                end else begin
                    state_s = SPLIT;
                end
            end
            default: begin
                state_s    = IDLE;
                nack_vld_s = 1'b0;
            end
        endcase

        if (cfg_psn_ld) begin
            e_psn_s = cfg_psn;
        end else if (inord_s) begin
            e_psn_s = e_psn_r + ONE_P;
        end else if (gap_s) begin
            e_psn_s = in_psn + ONE_P;
        end else begin
            e_psn_s = e_psn_r;
        end
    end

    // Sequencer state and descriptor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            e_psn_r    <= INIT_P;
            nack_psn_r <= '0;
            nack_len_r <= '0;
            nack_vld_r <= 1'b0;
            rem_r      <= '0;
            nxt_r      <= '0;
        end else begin
            state_r    <= state_s;
            e_psn_r    <= e_psn_s;
            nack_psn_r <= nack_psn_s;
            nack_len_r <= nack_len_s;
            nack_vld_r <= nack_vld_s;
            rem_r      <= rem_s;
            nxt_r      <= nxt_s;
        end
    end

`ifdef NACK_GAP_STAT_EN
    logic        dup_s;
    logic [31:0] stat_inord_r;
    logic [31:0] stat_gap_r;
    logic [31:0] stat_dup_r;

    assign dup_s = accept_s & diff_s[PSN_W-1];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    // Per-class acceptance counters, saturating, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_inord_r <= 32'd0;
            stat_gap_r   <= 32'd0;
            stat_dup_r   <= 32'd0;
        end else begin
            if (inord_s) begin
                stat_inord_r <= sat_inc(stat_inord_r);
            end
            if (gap_s) begin
                stat_gap_r <= sat_inc(stat_gap_r);
            end
            if (dup_s) begin
                stat_dup_r <= sat_inc(stat_dup_r);
            end
        end
    end

    assign stat_inord = stat_inord_r;
    assign stat_gap   = stat_gap_r;
    assign stat_dup   = stat_dup_r;
`endif

endmodule

// File: tb/tb_nack_gap_detector.sv
// Directed bench for nack_gap_detector: a queue-of-descriptors reference model checked every
// cycle, plus literal expectations for reset, gap, split, wrap, duplicate, backpressure and reset.
module tb_nack_gap_detector;

    localparam int unsigned PSN_W    = 24;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned MAX_LEN  = 64;
    localparam int unsigned INIT_PSN = 0;
    localparam int unsigned MASK     = (32'd1 << PSN_W) - 32'd1;
    localparam int unsigned HALF     = 32'd1 << (PSN_W - 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_psn_ld;
    logic [PSN_W-1:0] cfg_psn;
    logic [PSN_W-1:0] in_psn;
    logic             in_vld;
    logic             in_rdy;
    logic [PSN_W-1:0] nack_psn;
    logic [LEN_W-1:0] nack_len;
    logic             nack_vld;
    logic             nack_rdy;
`ifdef NACK_GAP_STAT_EN
    logic [31:0]      stat_inord;
    logic [31:0]      stat_gap;
    logic [31:0]      stat_dup;
`endif

    nack_gap_detector #(
        .PSN_W(PSN_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN), .INIT_PSN(INIT_PSN)
    ) dut (
        .clk(clk), .rst(rst), .cfg_psn_ld(cfg_psn_ld), .cfg_psn(cfg_psn),
        .in_psn(in_psn), .in_vld(in_vld), .in_rdy(in_rdy),
        .nack_psn(nack_psn), .nack_len(nack_len), .nack_vld(nack_vld), .nack_rdy(nack_rdy)
`ifdef NACK_GAP_STAT_EN
        , .stat_inord(stat_inord), .stat_gap(stat_gap), .stat_dup(stat_dup)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned psn;
        int unsigned len;
    } desc_t;

    desc_t       mq[$];     // descriptors still owed downstream, head = presented one
    desc_t       xlog[$];   // descriptors the DUT actually handed over
    int unsigned m_e;
    int unsigned m_inord, m_gap, m_dup;
    bit          started = 1'b0;

    // Reference model: gap -> whole list of chunks at once; pops on each transfer.
    initial begin
        forever begin
            int unsigned d, p, r, c;
            bit was_empty;
            @(posedge clk);
            if (!rst && nack_vld && nack_rdy) xlog.push_back('{psn: nack_psn, len: nack_len});
            if (rst) begin
                mq.delete();
                m_e = INIT_PSN;
                m_inord = 0; m_gap = 0; m_dup = 0;
            end else begin
                was_empty = (mq.size() == 0);
                if (!was_empty && nack_rdy) void'(mq.pop_front());
                if (cfg_psn_ld) begin
                    m_e = cfg_psn;
                end else if (in_vld && was_empty) begin
                    d = (in_psn - m_e) & MASK;
                    if (d == 0) begin
                        m_e = (m_e + 1) & MASK;
                        m_inord++;
                    end else if (d < HALF) begin
                        p = m_e;
                        r = d;
                        while (r > 0) begin
                            c = (r > MAX_LEN) ? MAX_LEN : r;
                            mq.push_back('{psn: p, len: c});
                            p = (p + c) & MASK;
                            r = r - c;
                        end
                        m_e = (in_psn + 1) & MASK;
                        m_gap++;
                    end else begin
                        m_dup++;
                    end
                end
            end
            started = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            check("model_in_rdy", 32'(in_rdy), 32'(mq.size() == 0 && !cfg_psn_ld && !rst));
            check("model_nack_vld", 32'(nack_vld), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("model_nack_psn", 32'(nack_psn), mq[0].psn);
                check("model_nack_len", 32'(nack_len), mq[0].len);
            end
`ifdef NACK_GAP_STAT_EN
            check("model_stat_inord", stat_inord, m_inord);
            check("model_stat_gap", stat_gap, m_gap);
            check("model_stat_dup", stat_dup, m_dup);
`endif
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PSN_W-1:0] p);
        int k;
        k = 0;
        in_psn = p;
        in_vld = 1'b1;
        @(negedge clk);
        while (!in_rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("send_accept", 32'(in_rdy), 32'd1);
        sync();
        in_vld = 1'b0;
    endtask

    task automatic cfg_load(input logic [PSN_W-1:0] v);
        cfg_psn = v;
        cfg_psn_ld = 1'b1;
        sync();
        cfg_psn_ld = 1'b0;
    endtask

    task automatic expect_desc(input string name, input int unsigned p, input int unsigned l);
        @(negedge clk);
        check({name, "_vld"}, 32'(nack_vld), 32'd1);
        check({name, "_psn"}, 32'(nack_psn), p);
        check({name, "_len"}, 32'(nack_len), l);
    endtask

    task automatic expect_quiet(input string name);
        @(negedge clk);
        check(name, 32'(nack_vld), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] pat;
        int unsigned exp_psn[4];
        int unsigned exp_len[4];
        pat = 9'b100110100;
        exp_psn = '{100, 164, 228, 292};
        exp_len = '{64, 64, 64, 8};

        rst = 1'b1; cfg_psn_ld = 1'b0; cfg_psn = '0; in_psn = '0; in_vld = 1'b0; nack_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_nack_vld", 32'(nack_vld), 32'd0);
        check("reset_nack_psn", 32'(nack_psn), 32'd0);
        check("reset_nack_len", 32'(nack_len), 32'd0);
        check("reset_in_rdy", 32'(in_rdy), 32'd0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_rdy", 32'(in_rdy), 32'd1);
        sync();

        // In order 0..9, then 10 must also be in order
        for (int i = 0; i < 10; i++) send(PSN_W'(i));
        expect_quiet("inorder_no_nack");
        send(PSN_W'(10));
        expect_quiet("inorder_e_psn_10");
        sync();

        // Simple gap
        cfg_load(PSN_W'(0));
        for (int i = 0; i < 5; i++) send(PSN_W'(i));
        send(PSN_W'(8));
        expect_desc("gap", 5, 3);
        sync();
        send(PSN_W'(9));
        expect_quiet("gap_then_inorder");
        sync();

        // Split with stalls
        nack_rdy = 1'b0;
        xlog.delete();
        cfg_load(PSN_W'(100));
        send(PSN_W'(300));
        expect_desc("split_first", 100, 64);
        sync();
        for (int i = 0; i < 9; i++) begin
            nack_rdy = pat[i];
            @(negedge clk);
            check("split_in_rdy_low", 32'(in_rdy), 32'd0);
            sync();
        end
        nack_rdy = 1'b1;
        @(negedge clk);
        check("split_done_in_rdy", 32'(in_rdy), 32'd1);
        check("split_count", 32'(xlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < xlog.size()) begin
                check("split_chunk_psn", xlog[i].psn, exp_psn[i]);
                check("split_chunk_len", xlog[i].len, exp_len[i]);
            end
        end
        sync();

        // Wrap-around
        cfg_load(PSN_W'(24'hFFFFFE));
        send(PSN_W'(1));
        expect_desc("wrap", 32'hFFFFFE, 3);
        sync();
        send(PSN_W'(2));
        expect_quiet("wrap_e_psn_2");
        sync();

        // Duplicate / old
        cfg_load(PSN_W'(50));
        send(PSN_W'(40));
        expect_quiet("dup_dropped");
        sync();
        send(PSN_W'(50));
        expect_quiet("dup_e_psn_50");
        sync();

        // Backpressure: held stable, in_rdy low
        nack_rdy = 1'b0;
        send(PSN_W'(60));
        for (int i = 0; i < 5; i++) begin
            expect_desc("stall", 51, 9);
            check("stall_in_rdy", 32'(in_rdy), 32'd0);
            sync();
        end
        // Reload while a descriptor is pending: descriptor unchanged, new e_psn used after
        cfg_load(PSN_W'(500));
        expect_desc("cfg_pending", 51, 9);
        sync();
        nack_rdy = 1'b1;
        sync();
        send(PSN_W'(500));
        expect_quiet("cfg_pending_e_psn");
        sync();

        // Reset in the middle of a split sequence
        nack_rdy = 1'b0;
        send(PSN_W'(700));
        expect_desc("presplit", 501, 64);
        sync();
        rst = 1'b1;
        sync();
        @(negedge clk);
        check("rst_split_nack_vld", 32'(nack_vld), 32'd0);
        check("rst_split_in_rdy", 32'(in_rdy), 32'd0);
        sync();
        rst = 1'b0;
        nack_rdy = 1'b1;
        send(PSN_W'(INIT_PSN));
        expect_quiet("rst_e_psn_init");
        sync();
        send(PSN_W'(5));
        expect_desc("rst_gap", 1, 4);
        sync();

        // cfg_psn_ld blocks acceptance in its own cycle
        cfg_psn = PSN_W'(1000);
        cfg_psn_ld = 1'b1;
        in_psn = PSN_W'(1000);
        in_vld = 1'b1;
        @(negedge clk);
        check("cfg_blocks_in_rdy", 32'(in_rdy), 32'd0);
        sync();
        cfg_psn_ld = 1'b0;
        @(negedge clk);
        check("cfg_after_in_rdy", 32'(in_rdy), 32'd1);
        sync();
        in_vld = 1'b0;
        expect_quiet("cfg_inorder");
        sync();
        send(PSN_W'(1001));
        expect_quiet("cfg_inorder_next");
        repeat (3) sync();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
